// File: rtl/vga_pkg.sv
// Shared timing, tilemap geometry and scan-bus types for the VGA tile front end.
package vga_pkg;

  localparam int unsigned H_SYNC     = 92;
  localparam int unsigned H_BACK     = 50;
  localparam int unsigned H_DISPLAY  = 640;
  localparam int unsigned H_FRONT    = 18;
  localparam int unsigned H_LINE     = H_SYNC + H_BACK + H_DISPLAY + H_FRONT;

  localparam int unsigned V_SYNC     = 2;
  localparam int unsigned V_BACK     = 33;
  localparam int unsigned V_DISPLAY  = 480;
  localparam int unsigned V_FRONT    = 10;
  localparam int unsigned V_FRAME    = V_SYNC + V_BACK + V_DISPLAY + V_FRONT;

  localparam int unsigned TILE_SHIFT = 5;
  localparam int unsigned MAP_COLS   = 20;
  localparam int unsigned MAP_ROWS   = 15;
  localparam int unsigned ROW_STRIDE = 16;

  localparam int unsigned GRASS      = 1;
  localparam int unsigned ROAD       = 2;

  localparam int unsigned H_CNT_W    = 10;
  localparam int unsigned V_CNT_W    = 10;
  localparam int unsigned X_W        = 10;
  localparam int unsigned Y_W        = 9;
  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned CELL_X_W   = 5;
  localparam int unsigned CELL_Y_W   = 4;
  localparam int unsigned PX_W       = 5;
  localparam int unsigned NIB_W      = 2;

  // Everything that travels down the delay line alongside the BRAM read.
  typedef struct packed {
    logic                hs;
    logic                vs;
    logic                act;
    logic [NIB_W-1:0]    nib;
    logic [CELL_X_W-1:0] cell_x;
    logic [CELL_Y_W-1:0] cell_y;
    logic [PX_W-1:0]     px_x;
    logic [PX_W-1:0]     px_y;
  } scan_t;

  localparam int unsigned SCAN_W = $bits(scan_t);

  localparam scan_t SCAN_RESET = '{
    hs:     1'b1,
    vs:     1'b1,
    act:    1'b0,
    nib:    '0,
    cell_x: '0,
    cell_y: '0,
    px_x:   '0,
    px_y:   '0
  };

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with asynchronous clear to a parameterised value.
module pipe_delay #(
  parameter int unsigned     WIDTH   = 8,
  parameter int unsigned     DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_shift
      logic [WIDTH-1:0] r_sr [DEPTH];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
        end else begin
          r_sr[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
      end

      assign o_q = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_tile_scanner.sv
// 640x480 raster counters, tilemap address generation and a delay line that
// aligns sync/cell outputs with the tilemap BRAM read data.
module vga_tile_scanner #(
  parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK     = vga_pkg::H_BACK,
  parameter int unsigned H_DISPLAY  = vga_pkg::H_DISPLAY,
  parameter int unsigned H_FRONT    = vga_pkg::H_FRONT,
  parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK     = vga_pkg::V_BACK,
  parameter int unsigned V_DISPLAY  = vga_pkg::V_DISPLAY,
  parameter int unsigned V_FRONT    = vga_pkg::V_FRONT,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic                          i_Clk,
  input  logic                          i_reset,
  output logic                          o_VGA_HSync,
  output logic                          o_VGA_VSync,
  output logic                          o_active,
  output logic [vga_pkg::ADDR_W-1:0]    o_map_addr,
  output logic [vga_pkg::NIB_W-1:0]     o_nibble_sel,
  output logic [vga_pkg::CELL_X_W-1:0]  o_cell_x,
  output logic [vga_pkg::CELL_Y_W-1:0]  o_cell_y,
  output logic [vga_pkg::PX_W-1:0]      o_px_x,
  output logic [vga_pkg::PX_W-1:0]      o_px_y,
  output logic                          o_frame_tick
);

  import vga_pkg::*;

  localparam int unsigned LINE_LEN  = H_SYNC + H_BACK + H_DISPLAY + H_FRONT;
  localparam int unsigned FRAME_LEN = V_SYNC + V_BACK + V_DISPLAY + V_FRONT;
  localparam int unsigned HA_START  = H_SYNC + H_BACK;
  localparam int unsigned HA_END    = HA_START + H_DISPLAY;
  localparam int unsigned VA_START  = V_SYNC + V_BACK;
  localparam int unsigned VA_END    = VA_START + V_DISPLAY;
  localparam int unsigned STRIDE_SH = $clog2(ROW_STRIDE);

  logic [H_CNT_W-1:0]  r_h_cnt;
  logic [V_CNT_W-1:0]  r_v_cnt;
  logic                w_h_last;
  logic                w_v_last;

  logic [X_W-1:0]      w_x;
  logic [Y_W-1:0]      w_y;
  logic                w_act;
  logic [CELL_X_W-1:0] w_cell_x;
  logic [CELL_Y_W-1:0] w_cell_y;
  logic [ADDR_W-1:0]   w_addr;
  scan_t               w_s0;

  scan_t               r_s0;
  logic [ADDR_W-1:0]   r_map_addr;
  logic                r_frame_tick;
  scan_t               w_dly;

  assign w_h_last = (r_h_cnt == H_CNT_W'(LINE_LEN - 1));
  assign w_v_last = (r_v_cnt == V_CNT_W'(FRAME_LEN - 1));

  // Raster position; the line counter advances only on the pixel-counter wrap.
  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + V_CNT_W'(1);
    end else begin
      r_h_cnt <= r_h_cnt + H_CNT_W'(1);
    end
  end

  // Stage-0 decode; everything positional is zeroed outside the visible window.
  always_comb begin
    w_x      = X_W'(r_h_cnt - H_CNT_W'(HA_START));
    w_y      = Y_W'(r_v_cnt - V_CNT_W'(VA_START));
    w_act    = (r_h_cnt >= H_CNT_W'(HA_START)) && (r_h_cnt < H_CNT_W'(HA_END)) &&
               (r_v_cnt >= V_CNT_W'(VA_START)) && (r_v_cnt < V_CNT_W'(VA_END));
    w_cell_x = CELL_X_W'(w_x >> TILE_SHIFT);
    w_cell_y = CELL_Y_W'(w_y >> TILE_SHIFT);
    w_addr   = '0;

    w_s0        = SCAN_RESET;
    w_s0.hs     = ~(r_h_cnt < H_CNT_W'(H_SYNC));
    w_s0.vs     = ~(r_v_cnt < V_CNT_W'(V_SYNC));
    w_s0.act    = w_act;
    if (w_act) begin
      w_addr      = (ADDR_W'(w_cell_y) << STRIDE_SH) + ADDR_W'(w_cell_x >> 2);
      w_s0.nib    = w_cell_x[NIB_W-1:0];
      w_s0.cell_x = w_cell_x;
      w_s0.cell_y = w_cell_y;
      w_s0.px_x   = w_x[PX_W-1:0];
      w_s0.px_y   = w_y[PX_W-1:0];
    end
  end

  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      r_s0         <= SCAN_RESET;
      r_map_addr   <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_s0         <= w_s0;
      r_map_addr   <= w_addr;
      r_frame_tick <= w_h_last && w_v_last;
    end
  end

  // Remaining stages so the delayed bus lands with the BRAM data and tile decode.
  pipe_delay #(
    .WIDTH   (SCAN_W),
    .DEPTH   (PIPE_DELAY - 1),
    .RST_VAL (SCAN_RESET)
  ) u_pipe_delay (
    .i_clk (i_Clk),
    .i_rst (i_reset),
    .i_d   (r_s0),
    .o_q   (w_dly)
  );

  assign o_VGA_HSync  = w_dly.hs;
  assign o_VGA_VSync  = w_dly.vs;
  assign o_active     = w_dly.act;
  assign o_nibble_sel = w_dly.nib;
  assign o_cell_x     = w_dly.cell_x;
  assign o_cell_y     = w_dly.cell_y;
  assign o_px_x       = w_dly.px_x;
  assign o_px_y       = w_dly.px_y;
  assign o_map_addr   = r_map_addr;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_tile_scanner.sv
// Directed bench for vga_tile_scanner on a shortened raster (652 x 40) so that
// several frames fit in a short run; horizontal display width stays at 640.
module tb_vga_tile_scanner;

  // Shortened timing: HA window [8,648), VA window [4,38), frame = 26080 clocks.
  localparam int unsigned T_H_SYNC = 4, T_H_BACK = 4, T_H_DISP = 640, T_H_FRONT = 4;
  localparam int unsigned T_V_SYNC = 2, T_V_BACK = 2, T_V_DISP = 34, T_V_FRONT = 2;
  localparam int unsigned FRAME    = 26080;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs, vs, act, tick;
  logic [10:0] addr;
  logic [1:0]  nib;
  logic [4:0]  cell_x;
  logic [3:0]  cell_y;
  logic [4:0]  px_x, px_y;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int n_wait;

  vga_tile_scanner #(
    .H_SYNC(T_H_SYNC), .H_BACK(T_H_BACK), .H_DISPLAY(T_H_DISP), .H_FRONT(T_H_FRONT),
    .V_SYNC(T_V_SYNC), .V_BACK(T_V_BACK), .V_DISPLAY(T_V_DISP), .V_FRONT(T_V_FRONT),
    .PIPE_DELAY(2)
  ) dut (
    .i_Clk        (clk),
    .i_reset      (rst),
    .o_VGA_HSync  (hs),
    .o_VGA_VSync  (vs),
    .o_active     (act),
    .o_map_addr   (addr),
    .o_nibble_sel (nib),
    .o_cell_x     (cell_x),
    .o_cell_y     (cell_y),
    .o_px_x       (px_x),
    .o_px_y       (px_y),
    .o_frame_tick (tick)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d (cyc=%0d)", tag, obs, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  // Steps until o_frame_tick is seen; n_wait = limit means it never came.
  task automatic wait_tick(input int limit);
    n_wait = 0;
    while (n_wait < limit) begin
      step();
      n_wait++;
      if (tick) break;
    end
  endtask

  initial begin
    repeat (10) @(posedge clk);
    #1;
    chk("rst_hs", int'(hs), 1);
    chk("rst_vs", int'(vs), 1);
    chk("rst_act", int'(act), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_tick", int'(tick), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    // Edge n: o_map_addr reflects raster position n-1, delayed outputs n-2.
    goto(1);    chk("hs_edge1", int'(hs), 1);
    goto(2);    chk("hs_edge2", int'(hs), 0);
                chk("vs_line0", int'(vs), 0);
    goto(5);    chk("hs_edge5", int'(hs), 0);
    goto(6);    chk("hs_edge6", int'(hs), 1);
    goto(1305); chk("vs_line1_end", int'(vs), 0);
    goto(1306); chk("vs_line2", int'(vs), 1);

    // Line 4 is the first visible line (y=0).
    goto(2617); chk("act_before", int'(act), 0);
    goto(2618); chk("act_first", int'(act), 1);
                chk("cx_first", int'(cell_x), 0);
                chk("cy_first", int'(cell_y), 0);
                chk("pxx_first", int'(px_x), 0);
                chk("pxy_first", int'(px_y), 0);
                chk("nib_first", int'(nib), 0);
    goto(2623); chk("pxx_x5", int'(px_x), 5);
    goto(2745); chk("addr_x128", int'(addr), 1);
    goto(2746); chk("cx_x128", int'(cell_x), 4);
                chk("nib_x128", int'(nib), 0);
    goto(2841); chk("addr_x224", int'(addr), 1);
    goto(2842); chk("cx_x224", int'(cell_x), 7);
                chk("nib_x224", int'(nib), 3);

    // Line 36 (y=32) starts tile row 1.
    goto(23481); chk("addr_y32", int'(addr), 16);
    goto(23482); chk("cy_y32", int'(cell_y), 1);
                 chk("pxy_y32", int'(px_y), 0);

    // Last visible pixel: line 37 (y=33), x=639.
    goto(24772); chk("addr_last", int'(addr), 20);
    goto(24773); chk("cx_last", int'(cell_x), 19);
                 chk("cy_last", int'(cell_y), 1);
                 chk("pxx_last", int'(px_x), 31);
                 chk("pxy_last", int'(px_y), 1);
                 chk("nib_last", int'(nib), 3);
                 chk("act_last", int'(act), 1);
                 chk("addr_blank", int'(addr), 0);
    goto(24774); chk("act_after", int'(act), 0);
                 chk("cx_blank", int'(cell_x), 0);
                 chk("pxx_blank", int'(px_x), 0);

    // Frame tick on the last raster position, one clock wide, once per frame.
    goto(FRAME - 1); chk("tick_pre", int'(tick), 0);
    goto(FRAME);     chk("tick_on", int'(tick), 1);
    goto(FRAME + 1); chk("tick_off", int'(tick), 0);
    wait_tick(30000);
    chk("tick_period", n_wait, FRAME - 1);
    step();
    chk("tick_width", int'(tick), 0);

    // Mid-frame reset while a visible pixel is on the outputs.
    goto(2 * FRAME + 20 * 652 + 300);
    chk("act_mid", int'(act), 1);
    rst = 1'b1;
    #1;
    chk("arst_hs", int'(hs), 1);
    chk("arst_vs", int'(vs), 1);
    chk("arst_act", int'(act), 0);
    chk("arst_addr", int'(addr), 0);
    chk("arst_cx", int'(cell_x), 0);
    chk("arst_pxy", int'(px_y), 0);
    @(posedge clk);
    #1;
    chk("arst_tick", int'(tick), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    goto(1); chk("rs_hs_edge1", int'(hs), 1);
    goto(2); chk("rs_hs_edge2", int'(hs), 0);
             chk("rs_vs_top", int'(vs), 0);
    wait_tick(30000);
    chk("rs_tick_first", cyc, FRAME);
    step();
    chk("rs_tick_width", int'(tick), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
